// File: rtl/flop_en_r.sv
// flop_en_r: parameterised D flip-flop with synchronous active-high reset
// and clock enable. This is the leaf storage cell that wider datapath
// registers and control-state registers are built from.
//
// Parameters:
//   WIDTH       - bit width of d and q
//   RESET_VALUE - value loaded into q on reset (WIDTH bits)
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous reset, active-high; takes priority over en
//   en    - load enable, active-high
//   d     - data input, sampled on a rising edge when en=1 and reset=0
//   q     - registered data output; no combinational path from any input
//
// q has no defined value until the first edge with reset=1 or en=1.
module flop_en_r #(
  parameter int unsigned             WIDTH       = 1,
  parameter logic        [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_flop_en_r.sv
// Testbench for flop_en_r: drives a 1-bit default instance and an 8-bit
// instance with RESET_VALUE=8'hA5 from shared reset/en, and checks both
// against a reference model of the register's update rules.
module tb_flop_en_r;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [0:0] d1;
  logic [0:0] q1;
  logic [7:0] d8;
  logic [7:0] q8;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: the value each register is expected to hold.
  logic [0:0] m1;
  logic [7:0] m8;
  bit         primed = 1'b0;

  always #5 clk = ~clk;

  flop_en_r dut1 (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .d    (d1),
    .q    (q1)
  );

  flop_en_r #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5)
  ) dut8 (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .d    (d8),
    .q    (q8)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, confirm q did not move
  // between edges, then apply the update rule at the rising edge and check.
  task automatic tick(input logic r, input logic e, input logic [0:0] a,
                      input logic [7:0] b, input string tag);
    @(negedge clk);
    reset = r;
    en    = e;
    d1    = a;
    d8    = b;
    #1;
    if (primed) begin
      chk({tag, "_mid_q1"}, {7'd0, q1}, {7'd0, m1});
      chk({tag, "_mid_q8"}, q8, m8);
    end
    @(posedge clk);
    if (r) begin
      m1     = 1'b0;
      m8     = 8'hA5;
      primed = 1'b1;
    end else if (e) begin
      m1     = a;
      m8     = b;
      primed = 1'b1;
    end
    #1;
    if (primed) begin
      chk({tag, "_q1"}, {7'd0, q1}, {7'd0, m1});
      chk({tag, "_q8"}, q8, m8);
    end
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    d1    = 1'b0;
    d8    = 8'h00;

    // Reset with enable and d=1 active: reset wins, held for three edges.
    tick(1'b1, 1'b1, 1'b1, 8'hFF, "reset0");
    tick(1'b1, 1'b1, 1'b1, 8'hFF, "reset1");
    tick(1'b1, 1'b1, 1'b1, 8'hFF, "reset2");

    // Load immediately after reset release, then load a different value.
    tick(1'b0, 1'b1, 1'b1, 8'h3C, "load1");
    tick(1'b0, 1'b1, 1'b0, 8'hC3, "load0");
    tick(1'b0, 1'b1, 1'b1, 8'h3C, "load1b");

    // Hold: en low, d toggles for four edges.
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'(i % 2), (i % 2 == 0) ? 8'hFF : 8'h00, "hold");
    end

    // Reset priority over enable.
    tick(1'b1, 1'b1, 1'b1, 8'hFF, "rst_prio");
    tick(1'b0, 1'b1, 1'b1, 8'h3C, "reload");

    // Reset pulse entirely between edges must not affect q.
    @(negedge clk);
    en    = 1'b0;
    d1    = 1'b0;
    d8    = 8'hFF;
    reset = 1'b1;
    #2;
    chk("pulse_during_q1", {7'd0, q1}, {7'd0, m1});
    chk("pulse_during_q8", q8, m8);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("pulse_after_q1", {7'd0, q1}, {7'd0, m1});
    chk("pulse_after_q8", q8, m8);

    // Reset held across an edge takes effect only at that edge.
    tick(1'b1, 1'b0, 1'b1, 8'hFF, "rst_edge");

    // Width behaviour: load 3C, then hold against d=FF.
    tick(1'b0, 1'b1, 1'b1, 8'h3C, "w_load");
    tick(1'b0, 1'b0, 1'b0, 8'hFF, "w_hold");

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           1'($urandom), 8'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
